// File: rtl/sh4a_fetch_pkg.sv
// Shared definitions for the SH4A instruction fetch stage: FSM states, reset vector,
// and the halfword queue entry layout.
package sh4a_fetch_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hA000_0000;

    localparam int unsigned INSN_W = 16;
    localparam int unsigned HPC_W  = 31;

    // One queued instruction; pc holds the halfword address (byte pc >> 1)
    typedef struct packed {
        logic [HPC_W-1:0]  pc;
        logic [INSN_W-1:0] insn;
    } hq_entry_t;

    function automatic hq_entry_t make_entry(input logic [HPC_W-1:0] hpc,
                                             input logic [INSN_W-1:0] insn);
        hq_entry_t e;
        e.pc   = hpc;
        e.insn = insn;
        return e;
    endfunction

endpackage

// File: rtl/sh4a_halfword_queue.sv
// Circular buffer of decoded-ready halfwords with dual push (low then high), single pop
// and flush. Flush takes priority over any same-cycle push or pop.
module sh4a_halfword_queue
    import sh4a_fetch_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push0,
    input  hq_entry_t                 push0_entry,
    input  logic                      push1,
    input  hq_entry_t                 push1_entry,
    input  logic                      pop,
    output hq_entry_t                 head,
    output logic [$clog2(QDEPTH):0]   count,
    output logic [$clog2(QDEPTH):0]   free
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;

    hq_entry_t        mem [QDEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
            count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    // Storage; push1 lands in the slot after push0 when both are present
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (!flush) begin
            if (push0) begin
                mem[wr_ptr] <= push0_entry;
            end
            if (push1) begin
                mem[wr_ptr + AW'(push0)] <= push1_entry;
            end
        end
    end

    assign head = mem[rd_ptr];
    assign free = CW'(QDEPTH) - count;

endmodule

// File: rtl/sh4a_fetch.sv
// SH4A fetch stage: issues aligned word reads, splits them into halfword instructions
// via a small queue, and handles redirects by flushing and discarding in-flight data.
module sh4a_fetch
    import sh4a_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        insn_valid,
    output logic [15:0] insn,
    output logic [31:0] insn_pc,
    input  logic        insn_ready
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [1:0]    state, state_nx;
    logic [31:0]   fetch_pc, fetch_nx;
    logic          skip_lo, skip_nx;
    logic          req_nx;
    logic [31:0]   addr_nx;

    logic          push0, push1, pop;
    hq_entry_t     push0_entry, push1_entry, head;
    hq_entry_t     lo_entry, hi_entry;
    logic [CW-1:0] q_count, q_free;
    logic [SW-1:0] used_after;
    logic          room_after;
    logic          unused_bits;

    assign unused_bits = redirect_pc[0];

    sh4a_halfword_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk         (clk),
        .reset       (reset),
        .flush       (redirect_valid),
        .push0       (push0),
        .push0_entry (push0_entry),
        .push1       (push1),
        .push1_entry (push1_entry),
        .pop         (pop),
        .head        (head),
        .count       (q_count),
        .free        (q_free)
    );

    assign insn_valid = (q_count != '0);
    assign insn       = head.insn;
    assign insn_pc    = {head.pc, 1'b0};
    assign pop        = insn_valid && insn_ready && !redirect_valid;

    assign lo_entry = make_entry({fetch_pc[31:2], 1'b0}, mem_rdata[15:0]);
    assign hi_entry = make_entry({fetch_pc[31:2], 1'b1}, mem_rdata[31:16]);

    // Reissue only if, after this push, another whole word still fits
    always_comb begin
        used_after = SW'(q_count) + (skip_lo ? SW'(1) : SW'(2)) + SW'(2);
        room_after = (used_after <= SW'(QDEPTH));
    end

    // Next-state and memory-port control
    always_comb begin
        state_nx    = state;
        req_nx      = mem_req;
        addr_nx     = mem_addr;
        fetch_nx    = fetch_pc;
        skip_nx     = skip_lo;
        push0       = 1'b0;
        push1       = 1'b0;
        push0_entry = skip_lo ? hi_entry : lo_entry;
        push1_entry = hi_entry;

        case (state)
            ST_IDLE: begin
                if (!redirect_valid && (q_free >= CW'(2))) begin
                    state_nx = ST_WAIT;
                    req_nx   = 1'b1;
                    addr_nx  = fetch_pc;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    push0    = 1'b1;
                    push1    = !skip_lo;
                    skip_nx  = 1'b0;
                    fetch_nx = fetch_pc + 32'd4;
                    if (room_after) begin
                        req_nx  = 1'b1;
                        addr_nx = fetch_pc + 32'd4;
                    end else begin
                        state_nx = ST_IDLE;
                        req_nx   = 1'b0;
                    end
                end
            end
            ST_DROP: begin
                if (mem_ack) begin
                    state_nx = ST_IDLE;
                    req_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                req_nx   = 1'b0;
            end
        endcase

        // Redirect wins; an un-acked request stays on the bus but its data is dropped
        if (redirect_valid) begin
            push0    = 1'b0;
            push1    = 1'b0;
            fetch_nx = {redirect_pc[31:2], 2'b00};
            skip_nx  = redirect_pc[1];
            if (mem_req && !mem_ack) begin
                state_nx = ST_DROP;
            end else begin
                state_nx = ST_IDLE;
                req_nx   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= {RESET_PC[31:2], 2'b00};
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            skip_lo  <= RESET_PC[1];
        end else begin
            state    <= state_nx;
            mem_req  <= req_nx;
            mem_addr <= addr_nx;
            fetch_pc <= fetch_nx;
            skip_lo  <= skip_nx;
        end
    end

endmodule

// File: tb/tb_sh4a_fetch.sv
// Self-checking bench for sh4a_fetch: memory responder, sequential-PC reference model.
module tb_sh4a_fetch;

    localparam logic [31:0] RST_PC = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        insn_valid;
    logic [15:0] insn;
    logic [31:0] insn_pc;
    logic        insn_ready;

    sh4a_fetch #(.RESET_PC(RST_PC), .QDEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .insn_valid     (insn_valid),
        .insn           (insn),
        .insn_pc        (insn_pc),
        .insn_ready     (insn_ready)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          req_cnt, proto_viol, age, ack_delay;
    bit          auto_ack, use_fixed, last_req, last_ack;
    logic [31:0] fixed_word;
    logic [31:0] exp_pc;
    logic [31:0] req_addrs[$];
    logic [47:0] got_q[$];

    // Memory image: each halfword's content is a fixed function of its address
    function automatic logic [15:0] hw(input logic [31:0] a);
        return a[16:1] ^ a[31:16] ^ 16'h5A5A;
    endfunction

    // One clock: respond to memory, record accepted insns and bus-protocol breaks
    task automatic step();
        bit          req_now, ack_now, rst_now, pop_hs, newreq;
        logic [31:0] a_now, pp;
        logic [15:0] pi;
        req_now = mem_req;
        a_now   = mem_addr;
        newreq  = mem_req && (!last_req || last_ack);
        if (newreq) begin
            req_cnt++;
            req_addrs.push_back(mem_addr);
            age = 0;
        end
        if (auto_ack) begin
            mem_ack   = mem_req && (age >= ack_delay);
            mem_rdata = use_fixed ? fixed_word : {hw(mem_addr + 32'd2), hw(mem_addr)};
        end
        if (mem_req) age++;
        ack_now = mem_ack;
        rst_now = reset;
        pop_hs  = insn_valid && insn_ready && !redirect_valid && !reset;
        pi      = insn;
        pp      = insn_pc;
        @(posedge clk);
        #1;
        if (pop_hs) got_q.push_back({pp, pi});
        if (req_now && !ack_now && !rst_now && (mem_req !== 1'b1 || mem_addr !== a_now))
            proto_viol++;
        last_req = rst_now ? 1'b0 : req_now;
        last_ack = ack_now;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        auto_ack = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        insn_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        req_cnt = 0;
        proto_viol = 0;
        last_req = 1'b0;
        last_ack = 1'b0;
        age = 0;
        got_q.delete();
        req_addrs.delete();
        exp_pc = RST_PC;
        use_fixed = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL reset_mem_req got=%b want=0", mem_req);
        end
        total++;
        if (insn_valid !== 1'b0) begin
            bad++; $display("FAIL reset_insn_valid got=%b want=0", insn_valid);
        end
        step();
        total++;
        if ({mem_req, mem_addr} !== {1'b1, RST_PC}) begin
            bad++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        logic [47:0] e;
        int n = 0;
        do_reset();
        use_fixed = 1'b1; fixed_word = 32'h0009_0009;
        auto_ack = 1'b1; ack_delay = 1; insn_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            step();
            while (got_q.size() > 0) begin
                e = got_q.pop_front(); n++; total++;
                if (e[47:16] !== exp_pc || e[15:0] !== 16'h0009) begin
                    bad++; $display("FAIL seq_pop got pc=%h insn=%h want pc=%h insn=0009", e[47:16], e[15:0], exp_pc);
                end
                exp_pc += 32'd2;
            end
        end
        total++;
        if (n < 8) begin bad++; $display("FAIL seq_count got=%0d want>=8", n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (req_addrs.size() <= i) begin
                bad++; $display("FAIL seq_addr missing req %0d", i);
            end else if (req_addrs[i] !== RST_PC + 32'(4 * i)) begin
                bad++; $display("FAIL seq_addr got=%h want=%h", req_addrs[i], RST_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] e;
        int n = 0;
        do_reset();
        auto_ack = 1'b1; ack_delay = 1; insn_ready = 1'b0;
        for (int c = 0; c < 20; c++) step();
        total++;
        if (req_cnt !== 2) begin bad++; $display("FAIL bp_reads got=%0d want=2", req_cnt); end
        total++;
        if ({mem_req, insn_valid} !== 2'b01) begin
            bad++; $display("FAIL bp_full got req=%b valid=%b want req=0 valid=1", mem_req, insn_valid);
        end
        insn_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            while (got_q.size() > 0) begin
                e = got_q.pop_front(); n++; total++;
                if (e[47:16] !== exp_pc || e[15:0] !== hw(exp_pc)) begin
                    bad++; $display("FAIL bp_pop got pc=%h insn=%h want pc=%h insn=%h", e[47:16], e[15:0], exp_pc, hw(exp_pc));
                end
                exp_pc += 32'd2;
            end
        end
        total++;
        if (n < 8 || req_cnt <= 2) begin
            bad++; $display("FAIL bp_resume got pops=%0d reads=%0d want pops>=8 reads>2", n, req_cnt);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        insn_ready = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h8C00_0102;
        step();
        redirect_valid = 1'b0;
        total++;
        if ({mem_req, mem_addr} !== {1'b1, RST_PC}) begin
            bad++; $display("FAIL rw_hold got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, RST_PC);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_ack = 1'b0;
        total++;
        if ({insn_valid, mem_req} !== 2'b00) begin
            bad++; $display("FAIL rw_drop got valid=%b req=%b want 0 0", insn_valid, mem_req);
        end
        step();
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h8C00_0100}) begin
            bad++; $display("FAIL rw_refetch got req=%b addr=%h want req=1 addr=8c000100", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
        step();
        mem_ack = 1'b0;
        total++;
        if ({insn_valid, insn, insn_pc} !== {1'b1, 16'h3333, 32'h8C00_0102}) begin
            bad++; $display("FAIL rw_insn got v=%b insn=%h pc=%h want v=1 insn=3333 pc=8c000102", insn_valid, insn, insn_pc);
        end
        step();
        total++;
        if (insn_valid !== 1'b0 || got_q.size() !== 1) begin
            bad++; $display("FAIL rw_single got valid=%b pops=%0d want valid=0 pops=1", insn_valid, got_q.size());
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        insn_ready = 1'b1;
        step();
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_BBBB;
        step();
        mem_rdata = 32'hCCCC_DDDD;
        redirect_valid = 1'b1; redirect_pc = 32'h8C00_0200;
        step();
        mem_ack = 1'b0; redirect_valid = 1'b0;
        total++;
        if ({insn_valid, mem_req} !== 2'b00) begin
            bad++; $display("FAIL ra_flush got valid=%b req=%b want 0 0", insn_valid, mem_req);
        end
        step();
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h8C00_0200}) begin
            bad++; $display("FAIL ra_reissue got req=%b addr=%h want req=1 addr=8c000200", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h7777_8888;
        step();
        mem_ack = 1'b0;
        total++;
        if ({insn_valid, insn, insn_pc} !== {1'b1, 16'h8888, 32'h8C00_0200} || got_q.size() !== 0) begin
            bad++; $display("FAIL ra_nodrop got v=%b insn=%h pc=%h pops=%0d want v=1 insn=8888 pc=8c000200 pops=0",
                            insn_valid, insn, insn_pc, got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        insn_ready = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h8C00_0000;
        step();
        redirect_pc = 32'h8C00_0010;
        step();
        redirect_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        step();
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h8C00_0010}) begin
            bad++; $display("FAIL bb_addr got req=%b addr=%h want req=1 addr=8c000010", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h5555_6666;
        step();
        mem_ack = 1'b0;
        total++;
        if (req_cnt !== 2) begin bad++; $display("FAIL bb_reads got=%0d want=2", req_cnt); end
        total++;
        if ({insn_valid, insn, insn_pc} !== {1'b1, 16'h6666, 32'h8C00_0010}) begin
            bad++; $display("FAIL bb_insn got v=%b insn=%h pc=%h want v=1 insn=6666 pc=8c000010", insn_valid, insn, insn_pc);
        end
    endtask

    task automatic test_slow_mem();
        logic [47:0] e;
        int n = 0;
        bit seen = 1'b0;
        do_reset();
        auto_ack = 1'b1; ack_delay = 5; insn_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            while (got_q.size() > 0) begin
                e = got_q.pop_front(); n++; total++;
                if (e[47:16] !== exp_pc || e[15:0] !== hw(exp_pc)) begin
                    bad++; $display("FAIL slow_pop got pc=%h insn=%h want pc=%h insn=%h", e[47:16], e[15:0], exp_pc, hw(exp_pc));
                end
                exp_pc += 32'd2;
            end
        end
        total++;
        if (proto_viol !== 0 || n < 8) begin
            bad++; $display("FAIL slow_stable got viol=%0d pops=%0d want viol=0 pops>=8", proto_viol, n);
        end
        auto_ack = 1'b0; mem_ack = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (mem_req) seen = 1'b1; else step();
        end
        step();
        step();
        total++;
        if (mem_req !== 1'b1 || proto_viol !== 0) begin
            bad++; $display("FAIL slow_wait got req=%b viol=%0d want req=1 viol=0", mem_req, proto_viol);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({mem_req, insn_valid} !== 2'b00) begin
            bad++; $display("FAIL slow_reset got req=%b valid=%b want 0 0", mem_req, insn_valid);
        end
    endtask

    task automatic test_random_stream();
        logic [47:0] e;
        logic [31:0] rpc;
        bit          redir;
        int          n = 0;
        do_reset();
        auto_ack = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            ack_delay  = $urandom_range(0, 3);
            insn_ready = ($urandom_range(0, 3) != 0);
            redir      = ($urandom_range(0, 19) == 0);
            rpc        = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            redirect_valid = redir;
            redirect_pc    = rpc;
            step();
            while (got_q.size() > 0) begin
                e = got_q.pop_front(); n++; total++;
                if (e[47:16] !== exp_pc || e[15:0] !== hw(exp_pc)) begin
                    bad++; $display("FAIL rnd_pop got pc=%h insn=%h want pc=%h insn=%h", e[47:16], e[15:0], exp_pc, hw(exp_pc));
                end
                exp_pc += 32'd2;
            end
            if (redir) exp_pc = {rpc[31:1], 1'b0};
        end
        redirect_valid = 1'b0;
        total++;
        if (proto_viol !== 0 || n < 300) begin
            bad++; $display("FAIL rnd_summary got viol=%0d pops=%0d want viol=0 pops>=300", proto_viol, n);
        end
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        insn_ready = 1'b0;
        fixed_word = '0;
        ack_delay = 1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack();
        test_back_to_back();
        test_slow_mem();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
